// File: rtl/ram_arb_pkg.sv
// Shared types and encodings for the two-port BRAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] RAM_EN_IDLE  = 2'b00;
    localparam logic [1:0] RAM_EN_READ  = 2'b01;
    localparam logic [1:0] RAM_EN_WRITE = 2'b10;

    typedef logic port_id_t;

    localparam port_id_t PORT_FETCH = 1'b0;
    localparam port_id_t PORT_LS    = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of client-port and RAM_wrapper-side signals around ram_arbiter.
// slave = arbiter's view, master = environment (clients + wrapper) view.
interface ram_arbiter_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 p0_req;
    logic [BUS_WIDTH-1:0] p0_addr;
    logic                 p0_ack;
    logic [BUS_WIDTH-1:0] p0_rdata;

    logic                 p1_req;
    logic                 p1_we;
    logic [BUS_WIDTH-1:0] p1_addr;
    logic [BUS_WIDTH-1:0] p1_wdata;
    logic                 p1_ack;
    logic [BUS_WIDTH-1:0] p1_rdata;

    logic                 err;

    logic [1:0]           ram_en;
    logic [BUS_WIDTH-1:0] ram_addr_rd;
    logic [BUS_WIDTH-1:0] ram_addr_w;
    logic [BUS_WIDTH-1:0] ram_dwrite;
    logic [BUS_WIDTH-1:0] ram_dout;
    logic                 ram_busy;

    modport slave (
        input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, ram_dout, ram_busy,
        output p0_ack, p0_rdata, p1_ack, p1_rdata, err,
               ram_en, ram_addr_rd, ram_addr_w, ram_dwrite
    );

    modport master (
        output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, ram_dout, ram_busy,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata, err,
               ram_en, ram_addr_rd, ram_addr_w, ram_dwrite
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin grant: on a tie the port not served last wins.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  port_id_t   served,
    output logic       grant_valid,
    output port_id_t   grant
);

    port_id_t last_reg;

    // Port 1 counts as last served out of reset so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= PORT_LS;
        end else if (update) begin
            last_reg <= served;
        end
    end

    always_comb begin
        grant_valid = |req;
        grant       = PORT_FETCH;
        if (req == 2'b10) begin
            grant = PORT_LS;
        end else if (req == 2'b11) begin
            grant = ~last_reg;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM_wrapper between fetch (port 0) and load/store (port 1).
// Optional busy watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    ram_arbiter_if.slave bus
);

    state_t               state_reg;
    logic                 first_wait_reg;
    port_id_t             gnt_reg;
    logic                 we_reg;
    logic [1:0]           en_reg;
    logic [BUS_WIDTH-1:0] addr_reg;
    logic [BUS_WIDTH-1:0] wdata_reg;
    logic [1:0]           ack_reg;
    logic                 err_reg;

    logic                 grant_valid;
    port_id_t             grant;
    logic                 busy_done;
    logic                 tmo_hit;
    logic                 capture;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         ({bus.p1_req, bus.p0_req}),
        .update      (state_reg == DONE),
        .served      (gnt_reg),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // The wrapper raises busy one cycle after en, so the first WAIT sample is stale.
    assign busy_done = (state_reg == WAIT) && !first_wait_reg && !bus.ram_busy;
    assign capture   = busy_done && !we_reg;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ISSUE) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign tmo_hit = (state_reg == WAIT) && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // The watchdog limit only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            first_wait_reg <= 1'b0;
            gnt_reg        <= PORT_FETCH;
            we_reg         <= 1'b0;
            en_reg         <= RAM_EN_IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            ack_reg        <= 2'b00;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        gnt_reg   <= grant;
                        we_reg    <= (grant == PORT_LS) && bus.p1_we;
                        addr_reg  <= (grant == PORT_LS) ? bus.p1_addr : bus.p0_addr;
                        wdata_reg <= (grant == PORT_LS) ? bus.p1_wdata : '0;
                        en_reg    <= ((grant == PORT_LS) && bus.p1_we) ? RAM_EN_WRITE : RAM_EN_READ;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    en_reg         <= RAM_EN_IDLE;
                    first_wait_reg <= 1'b1;
                    state_reg      <= WAIT;
                end
                WAIT: begin
                    first_wait_reg <= 1'b0;
                    if (busy_done || tmo_hit) begin
                        ack_reg   <= (gnt_reg == PORT_LS) ? 2'b10 : 2'b01;
                        err_reg   <= !busy_done;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    ack_reg   <= 2'b00;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        logic [BUS_WIDTH-1:0] rdata_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_reg <= '0;
            end else if (capture && (gnt_reg == port_id_t'(gi))) begin
                rdata_reg <= bus.ram_dout;
            end
        end
    end

    assign bus.p0_ack      = ack_reg[0];
    assign bus.p1_ack      = ack_reg[1];
    assign bus.p0_rdata    = g_rdata[0].rdata_reg;
    assign bus.p1_rdata    = g_rdata[1].rdata_reg;
    assign bus.ram_en      = en_reg;
    assign bus.ram_addr_rd = addr_reg;
    assign bus.ram_addr_w  = addr_reg;
    assign bus.ram_dwrite  = wdata_reg;

`ifdef RAM_ARB_TIMEOUT_EN
    assign bus.err = err_reg;
`else
    assign bus.err = 1'b0;
`endif

endmodule
